// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl
//   Slew-rate limited servo position generator. Once per frame the block
//   samples the requested target and mode, then moves the registered position
//   by at most one step: toward the target in track mode, or back and forth
//   across the full 0..255 range in sweep mode.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   mode_sel   0 = track target, 1 = autonomous sweep 0..255..0
//   target     requested position code (track mode)
//   step       position increment per frame, 0 treated as 1
//   position   registered slewed position for the PWM stage
//   frame_tick one-cycle pulse in the last cycle of every frame
//   at_target  position has reached the sampled target (always low in sweep)

module servo_slew_ctrl #(
  parameter int unsigned FRAME_CYCLES = 1_000_000,
  parameter logic [7:0]  CENTER       = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_sel,
  input  logic [7:0] target,
  input  logic [3:0] step,
  output logic [7:0] position,
  output logic       frame_tick,
  output logic       at_target
);

  localparam logic [19:0] LAST_CNT = 20'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD,
    UP,
    DOWN,
    SWEEP_UP,
    SWEEP_DOWN
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] frame_ctr, frame_ctr_nxt;
  logic [7:0]  position_nxt;
  logic [7:0]  target_q, target_nxt;
  logic        mode_q, mode_nxt;
  logic        tick_nxt;
  logic [3:0]  step_eff;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic        go_up;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_ctr  <= '0;
      frame_tick <= 1'b0;
      position   <= CENTER;
      target_q   <= CENTER;
      mode_q     <= 1'b0;
      state      <= HOLD;
    end else begin
      frame_ctr  <= frame_ctr_nxt;
      frame_tick <= tick_nxt;
      position   <= position_nxt;
      target_q   <= target_nxt;
      mode_q     <= mode_nxt;
      state      <= state_nxt;
    end
  end

  always_comb begin
    frame_ctr_nxt = (frame_ctr == LAST_CNT) ? '0 : frame_ctr + 20'd1;
    // Registered tick lines up with the cycle where the counter shows the last count.
    tick_nxt      = (frame_ctr_nxt == LAST_CNT);

    step_eff = (step == 4'd0) ? 4'd1 : step;
    // 9-bit arithmetic: bit 8 flags overflow past 255 or underflow below 0.
    sum9     = {1'b0, position} + {5'b0, step_eff};
    diff9    = {1'b0, position} - {5'b0, step_eff};
    go_up    = (state == SWEEP_UP) ||
               ((state != SWEEP_DOWN) && (position != 8'hFF));

    state_nxt    = state;
    position_nxt = position;
    target_nxt   = target_q;
    mode_nxt     = mode_q;

    if (frame_tick) begin
      target_nxt = target;
      mode_nxt   = mode_sel;
      if (!mode_sel) begin
        if (target > position) begin
          state_nxt    = UP;
          position_nxt = (sum9 > {1'b0, target}) ? target : sum9[7:0];
        end else if (target < position) begin
          state_nxt    = DOWN;
          position_nxt = (diff9[8] || (diff9[7:0] < target)) ? target : diff9[7:0];
        end else begin
          state_nxt = HOLD;
        end
      end else if (go_up) begin
        if (sum9 >= 9'd255) begin
          position_nxt = 8'hFF;
          state_nxt    = SWEEP_DOWN;
        end else begin
          position_nxt = sum9[7:0];
          state_nxt    = SWEEP_UP;
        end
      end else begin
        if (diff9[8] || (diff9 == 9'd0)) begin
          position_nxt = 8'h00;
          state_nxt    = SWEEP_UP;
        end else begin
          position_nxt = diff9[7:0];
          state_nxt    = SWEEP_DOWN;
        end
      end
    end
  end

  assign at_target = (state == HOLD) || (!mode_q && (position == target_q));

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb_servo_slew_ctrl
//   Directed frame/slew scenarios with fixed expected values, followed by a
//   randomized run compared cycle by cycle against a behavioural model.

module tb_servo_slew_ctrl;

  localparam int unsigned FC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_sel = 1'b0;
  logic [7:0] target = 8'd128;
  logic [3:0] step = 4'd1;
  logic [7:0] position;
  logic       frame_tick;
  logic       at_target;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int m_ctr = 0;
  int m_pos = 128;
  int m_tgt = 128;
  bit m_mode = 1'b0;
  bit m_sweep = 1'b0;
  bit m_up = 1'b1;

  servo_slew_ctrl #(
    .FRAME_CYCLES(FC),
    .CENTER(8'd128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_sel(mode_sel),
    .target(target),
    .step(step),
    .position(position),
    .frame_tick(frame_tick),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sees at that edge.
  task automatic model_step();
    int s;
    if (!rst) begin
      m_ctr = 0; m_pos = 128; m_tgt = 128;
      m_mode = 1'b0; m_sweep = 1'b0; m_up = 1'b1;
      return;
    end
    if (m_ctr == int'(FC) - 1) begin
      s = (step == 4'd0) ? 1 : int'(step);
      m_tgt  = int'(target);
      m_mode = mode_sel;
      if (!mode_sel) begin
        m_sweep = 1'b0;
        if (m_tgt > m_pos)
          m_pos = (m_pos + s > m_tgt) ? m_tgt : m_pos + s;
        else if (m_tgt < m_pos)
          m_pos = (m_pos - s < m_tgt) ? m_tgt : m_pos - s;
      end else begin
        if (!m_sweep) begin
          m_sweep = 1'b1;
          m_up = (m_pos != 255);
        end
        if (m_up) m_pos = (m_pos + s > 255) ? 255 : m_pos + s;
        else      m_pos = (m_pos - s < 0) ? 0 : m_pos - s;
        if (m_pos == 255) m_up = 1'b0;
        else if (m_pos == 0) m_up = 1'b1;
      end
    end
    m_ctr = (m_ctr + 1) % int'(FC);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench in the first cycle after reset (frame counter at 0).
  task automatic do_reset();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  // Run through the next tick cycle; returns with the new position visible.
  task automatic next_update();
    int n = 0;
    while (!frame_tick && n < 2 * int'(FC)) begin
      cycle();
      n++;
    end
    if (!frame_tick) check("tick_timeout", 0, 1);
    cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b[4]  = '{132, 136, 140, 140};
    int exp_bt[4] = '{0, 0, 1, 1};
    int exp_c[4]  = '{127, 126, 125, 125};
    int exp_ct[4] = '{0, 0, 1, 1};
    int exp_d[3]  = '{255, 240, 225};
    int r;

    @(negedge clk);

    // reset state and tick timing
    do_reset();
    check("reset_position", int'(position), 128);
    check("reset_at_target", int'(at_target), 1);
    for (int k = 1; k <= 35; k++) begin
      check($sformatf("tick_c%0d", k), int'(frame_tick), (k % 10 == 0) ? 1 : 0);
      cycle();
    end

    // track up
    target = 8'd140; step = 4'd4; mode_sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_update();
      check($sformatf("trackup_pos%0d", i), int'(position), exp_b[i]);
      check($sformatf("trackup_at%0d", i), int'(at_target), exp_bt[i]);
    end

    // step 0 behaves as 1, no overshoot on the way down
    target = 8'd125; step = 4'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_update();
      check($sformatf("step0_pos%0d", i), int'(position), exp_c[i]);
      check($sformatf("step0_at%0d", i), int'(at_target), exp_ct[i]);
    end

    // sweep reversal at both ends
    target = 8'd250; step = 4'd15; mode_sel = 1'b0;
    do_reset();
    repeat (9) next_update();
    check("sweep_pre250", int'(position), 250);
    mode_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_update();
      check($sformatf("sweep_top%0d", i), int'(position), exp_d[i]);
      check($sformatf("sweep_at%0d", i), int'(at_target), 0);
    end
    repeat (14) next_update();
    check("sweep_15", int'(position), 15);
    step = 4'd5;
    next_update();
    check("sweep_10", int'(position), 10);
    step = 4'd15;
    next_update();
    check("sweep_bottom0", int'(position), 0);
    next_update();
    check("sweep_back15", int'(position), 15);

    // mid-frame target change waits for the next tick
    target = 8'd128; step = 4'd4; mode_sel = 1'b0;
    do_reset();
    next_update();
    cycle();
    cycle();
    target = 8'd200;
    r = 0;
    while (!frame_tick && r < 2 * int'(FC)) begin
      check("midframe_hold", int'(position), 128);
      check("midframe_at", int'(at_target), 1);
      cycle();
      r++;
    end
    check("midframe_tick_seen", int'(frame_tick), 1);
    cycle();
    check("midframe_after", int'(position), 132);
    check("midframe_after_at", int'(at_target), 0);

    // reset during sweep
    target = 8'd0; step = 4'd8; mode_sel = 1'b1;
    do_reset();
    repeat (9) next_update();
    check("rstsweep_200", int'(position), 200);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    mode_sel = 1'b0;
    target = 8'd128;
    check("rstsweep_pos", int'(position), 128);
    check("rstsweep_at", int'(at_target), 1);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("rstsweep_notick%0d", k), int'(frame_tick), 0);
      cycle();
    end
    check("rstsweep_first_tick", int'(frame_tick), 1);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) mode_sel = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 4) begin
        r = $urandom_range(0, 5);
        target = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) < 4) step = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 599) != 0);
      cycle();
      check("rand_pos", int'(position), m_pos);
      check("rand_tick", int'(frame_tick), (m_ctr == int'(FC) - 1) ? 1 : 0);
      check("rand_at", int'(at_target), (!m_mode && m_pos == m_tgt) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
